nn_error_stage: RTL
===================

NN_ERROR_STAGE -- requirements
Module: nn_error_stage

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 40, giving the number of outputs per batch before done pulses.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port z_valid, input, 1 bit: z_data and z_label are valid.
REQ-005 SHALL have port z_ready, output, 1 bit: the stage accepts an input this cycle.
REQ-006 SHALL have port z_data, input, 32 bits: signed forward sum in Q.16 (invec Q.8 x weight Q.8).
REQ-007 SHALL have port z_label, input, 1 bit: target y for this sample (1 means 1.0, 0 means 0.0).
REQ-008 SHALL have port err_valid, output, 1 bit: err_data and ycap_data are valid.
REQ-009 SHALL have port err_ready, input, 1 bit: the downstream backprop stage accepts the output.
REQ-010 SHALL have port ycap_data, output, 10 bits: unsigned sigmoid in Q1.8, where 256 means 1.0.
REQ-011 SHALL have port err_data, output, 16 bits: signed ycap - y in Q.8, sign-extended.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse on transfer of the N_SAMPLES-th output.
REQ-013 SHALL have port correct_cnt, output, 7 bits: correct classifications in the last completed batch.

Function
REQ-014 SHALL use a transfer rule: input transfer = z_valid & z_ready; output transfer = err_valid & err_ready.
REQ-015 SHALL define advance = !err_valid | err_ready, and z_ready SHALL equal advance combinationally.
REQ-016 SHALL use a 2-stage pipeline, S1 then output register, with 2-cycle latency from input transfer to err_valid when there is no stall; it SHALL sustain 1 transfer per cycle.
REQ-017 SHALL freeze both stages, the LUT read included, while advance=0; held outputs SHALL NOT change while err_valid=1 and err_ready=0.
REQ-018 SHALL register the following in S1: sat_hi = z>=524288; sat_lo = z<=-524288; neg = z<0; idx = |z|[18:8]; label.
REQ-019 SHALL have the LUT return sig = round(256/(1+e^(-idx/256))), clipped to 255; sig(0)=128.
REQ-020 SHALL produce ycap = 256 if sat_hi; 0 if sat_lo; 256-sig if neg; otherwise sig.
REQ-021 SHALL produce err = ycap - (label ? 256 : 0), a signed value in the range -256..+256, sign-extended to 16 bits.
REQ-022 SHALL count a sample as correct when (ycap>=128) equals label.
REQ-023 SHALL count output transfers; on the N_SAMPLES-th transfer it SHALL pulse done, load correct_cnt with the batch total (including this sample), and clear the internal counters in the same cycle.
REQ-024 SHALL let S1 valid update on advance to the value of the input transfer (bubbles propagate), and SHALL let the output valid update on advance to the S1 valid.

Reset
REQ-025 SHALL, on rst, clear err_valid, S1 valid, done, the sample counter, the correct counter and correct_cnt to 0, and set err_data and ycap_data to 0.
REQ-026 SHALL make z_ready 1 in the first cycle after reset.
REQ-027 SHALL discard all in-flight samples when rst is asserted mid-batch, with no done pulse; the next batch SHALL count from 0.

Structure
REQ-028 SHALL place constants in the shared package nn_pkg: Q8_ONE=256, Q8_HALF=128, SAT_POS=524288, SAT_NEG=-524288, LUT_AW=11, LUT_DW=8.
REQ-029 SHALL implement the LUT as one sub-module, sigmoid_lut, with an 11-bit address, 8-bit data, a registered read and a clock enable, ROM-inferable.

Verification
REQ-030 SHALL pass the basic-values scenario: z=0 with label=1 SHALL give ycap=128 and err=-128 two cycles later; z=0 with label=0 SHALL give err=+128.
REQ-031 SHALL pass the saturation scenario: z=524288 with label=1 SHALL give ycap=256 and err=0; z=-524288 with label=1 SHALL give ycap=0 and err=-256; z=524287 SHALL give ycap=255.
REQ-032 SHALL pass the symmetry scenario: z=+65536 then z=-65536 SHALL give ycap=187 then ycap=69, summing to 256.
REQ-033 SHALL pass the backpressure scenario: with 40 back-to-back inputs and err_ready toggling 1,0,0,1, there SHALL be no loss or duplication, outputs SHALL stay in order, and held values SHALL be stable during stalls.
REQ-034 SHALL pass the batch scenario: 40 samples with 25 correct SHALL give done high for exactly 1 cycle on the 40th output transfer and correct_cnt=25; a 41st sample SHALL start a new count.
REQ-035 SHALL pass the mid-reset scenario: rst after 17 transfers SHALL give err_valid=0 next cycle, and then 40 further samples SHALL give exactly one done.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and stage-1 record for the error stage of the perceptron datapath.
// All fixed-point values are Q.8 unless the name says otherwise.
package nn_pkg;

    localparam int Q8_ONE  = 256;
    localparam int Q8_HALF = 128;
    localparam logic signed [31:0] SAT_POS = 32'sd524288;
    localparam logic signed [31:0] SAT_NEG = -32'sd524288;
    localparam int LUT_AW  = 11;
    localparam int LUT_DW  = 8;
    localparam int YCAP_W  = 10;
    localparam int ERR_W   = 16;
    localparam int CNT_W   = 7;

    typedef struct packed {
        logic sat_hi;
        logic sat_lo;
        logic neg;
        logic label;
    } s1_t;

endpackage

// File: rtl/sigmoid_lut.sv
// Registered-read sigmoid ROM: o_data = round(256 / (1 + e^(-addr/256))), clipped to 255.
// Contents are fixed at elaboration so the array maps onto a block ROM.
module sigmoid_lut
    import nn_pkg::*;
(
    input  logic              clk,
    input  logic              i_en,
    input  logic [LUT_AW-1:0] i_addr,
    output logic [LUT_DW-1:0] o_data
);

    function automatic logic [LUT_DW-1:0] sig_round(input int idx);
        real v;
        int  r;
        v = 256.0 / (1.0 + $exp(-$itor(idx) / 256.0));
        r = $rtoi(v + 0.5);
        if (r > 255) r = 255;
        return r[LUT_DW-1:0];
    endfunction

    logic [LUT_DW-1:0] w_rom [0:(1 << LUT_AW)-1];
    logic [LUT_DW-1:0] r_data;

    for (genvar g = 0; g < (1 << LUT_AW); g++) begin : g_rom
        localparam logic [LUT_DW-1:0] ENTRY = sig_round(g);
        assign w_rom[g] = ENTRY;
    end

    always_ff @(posedge clk) begin
        if (i_en) r_data <= w_rom[i_addr];
    end

    assign o_data = r_data;

endmodule

// File: rtl/nn_error_stage.sv
// Sigmoid activation and output error for one sample per cycle, with per-batch
// accuracy count. Two pipeline stages, both frozen while the output is stalled.
module nn_error_stage
    import nn_pkg::*;
#(
    parameter int N_SAMPLES = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        z_valid,
    output logic        z_ready,
    input  logic [31:0] z_data,
    input  logic        z_label,
    output logic        err_valid,
    input  logic        err_ready,
    output logic [9:0]  ycap_data,
    output logic [15:0] err_data,
    output logic        done,
    output logic [6:0]  correct_cnt
);

    function automatic logic [YCAP_W-1:0] ycap_sel(input s1_t s, input logic [LUT_DW-1:0] sig);
        if (s.sat_hi) return YCAP_W'(Q8_ONE);
        if (s.sat_lo) return '0;
        if (s.neg)    return YCAP_W'(Q8_ONE) - {2'b00, sig};
        return {2'b00, sig};
    endfunction

    function automatic logic signed [ERR_W-1:0] err_calc(input logic [YCAP_W-1:0] y, input logic lbl);
        return $signed({6'd0, y}) - (lbl ? 16'sd256 : 16'sd0);
    endfunction

    logic                     w_adv;
    logic                     w_in_xfer;
    logic                     w_out_xfer;
    logic signed [31:0]       w_z;
    logic [18:0]              w_abs;
    logic [LUT_AW-1:0]        w_idx;
    logic [7:0]               w_unused_frac;
    logic [LUT_DW-1:0]        w_sig_p1;
    logic [YCAP_W-1:0]        w_ycap_p1;
    logic signed [ERR_W-1:0]  w_err_p1;
    logic                     w_correct;

    s1_t                      r_s1_p1;
    logic                     r_vld_p1;
    logic [YCAP_W-1:0]        r_ycap_p2;
    logic signed [ERR_W-1:0]  r_err_p2;
    logic                     r_lbl_p2;
    logic                     r_vld_p2;
    logic [CNT_W-1:0]         r_samp_cnt;
    logic [CNT_W-1:0]         r_corr_cnt;
    logic [CNT_W-1:0]         r_corr_out;
    logic                     r_done;

    assign w_adv      = !r_vld_p2 || err_ready;
    assign w_in_xfer  = z_valid && w_adv;
    assign w_out_xfer = r_vld_p2 && err_ready;

    // Only bits 18:8 of |z| address the LUT; the low 19 bits suffice because
    // anything larger is already saturated.
    assign w_z           = $signed(z_data);
    assign w_abs         = w_z[31] ? (~z_data[18:0] + 19'd1) : z_data[18:0];
    assign w_idx         = w_abs[18:8];
    assign w_unused_frac = w_abs[7:0];

    // Stage p1: classify z and start the LUT read
    always_ff @(posedge clk) begin
        if (rst)        r_vld_p1 <= 1'b0;
        else if (w_adv) r_vld_p1 <= w_in_xfer;
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s1_p1.sat_hi <= (w_z >= SAT_POS);
            r_s1_p1.sat_lo <= (w_z <= SAT_NEG);
            r_s1_p1.neg    <= w_z[31];
            r_s1_p1.label  <= z_label;
        end
    end

    sigmoid_lut u_lut (
        .clk    (clk),
        .i_en   (w_adv),
        .i_addr (w_idx),
        .o_data (w_sig_p1)
    );

    assign w_ycap_p1 = ycap_sel(r_s1_p1, w_sig_p1);
    assign w_err_p1  = err_calc(w_ycap_p1, r_s1_p1.label);

    // Stage p2: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_ycap_p2 <= '0;
            r_err_p2  <= '0;
        end else if (w_adv) begin
            r_vld_p2  <= r_vld_p1;
            r_ycap_p2 <= w_ycap_p1;
            r_err_p2  <= w_err_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) r_lbl_p2 <= r_s1_p1.label;
    end

    assign w_correct = ((r_ycap_p2 >= YCAP_W'(Q8_HALF)) == r_lbl_p2);

    // Batch bookkeeping on output transfers; the last sample of a batch is
    // included in the published total and the counters restart in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_samp_cnt <= '0;
            r_corr_cnt <= '0;
            r_corr_out <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_out_xfer) begin
                if (r_samp_cnt == CNT_W'(N_SAMPLES - 1)) begin
                    r_done     <= 1'b1;
                    r_corr_out <= r_corr_cnt + CNT_W'(w_correct);
                    r_samp_cnt <= '0;
                    r_corr_cnt <= '0;
                end else begin
                    r_samp_cnt <= r_samp_cnt + CNT_W'(1);
                    r_corr_cnt <= r_corr_cnt + CNT_W'(w_correct);
                end
            end
        end
    end

    assign z_ready     = w_adv;
    assign err_valid   = r_vld_p2;
    assign ycap_data   = r_ycap_p2;
    assign err_data    = r_err_p2;
    assign done        = r_done;
    assign correct_cnt = r_corr_out;

endmodule
